// File: rtl/i2c_codec_cfg_seq.sv
// Codec configuration sequencer with an integrated open-drain I2C write master.
// Fetches 16-bit register words from an external table and sends each as
// {addr byte, high byte, low byte}. Every byte is ACK-checked. A NACKed word is
// retried up to MAX_RETRY extra times before the run aborts and reports the
// failing index. A single-word rewrite mode reuses the same datapath.
module i2c_codec_cfg_seq #(
    parameter int         NUM_REGS  = 11,
    parameter logic [6:0] DEV_ADDR  = 7'h1A,
    parameter int         CLK_DIV   = 125,
    parameter int         MAX_RETRY = 3,
    parameter int         IDX_W     = 8
) (
    input  logic             clk_50mhz,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             start_cf_i,
    input  logic             wr_one_i,
    input  logic [IDX_W-1:0] wr_idx_i,
    output logic [IDX_W-1:0] tbl_idx_o,
    input  logic [15:0]      tbl_data_i,
    input  logic             i2c_sda_i,
    output logic             i2c_sda_oe_o,
    output logic             i2c_sclk_o,
    output logic             busy_o,
    output logic             cf_done_o,
    output logic             cf_err_o,
    output logic [IDX_W-1:0] err_idx_o
);

    localparam int               CNT_W    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
    localparam logic [2:0]       RETRY_LIM = 3'(MAX_RETRY);

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       phase_r;
    logic [2:0]       bit_r;
    logic [1:0]       byte_r;
    logic [23:0]      shift_r;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] last_r;
    logic [2:0]       retry_r;
    logic             nack_r;
    logic             load_wait_r;

    logic             run_s;
    logic             tick_s;
    logic             idx_ok_s;
    logic             start_ok_s;
    logic             scl_s;
    logic             oe_s;

    // The quarter-bit timebase only runs while a frame is on the bus
    assign run_s      = (state_r == S_START) || (state_r == S_BIT) || (state_r == S_ACK) ||
                        (state_r == S_STOP)  || (state_r == S_GAP);
    assign tick_s     = run_s && (cnt_r == CNT_MAX);
    assign idx_ok_s   = ({1'b0, wr_idx_i} < (IDX_W + 1)'(NUM_REGS));
    assign start_ok_s = en_i && (start_cf_i || (wr_one_i && idx_ok_s));

    // Quarter-SCL tick counter, held at zero outside the bus states
    always_ff @(posedge clk_50mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= '0;
        end else if (!run_s || (cnt_r == CNT_MAX)) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    // Sequencer: run qualification, word fetch, bit framing, ACK check and retry policy
    always_ff @(posedge clk_50mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= S_IDLE;
            phase_r     <= 2'd0;
            bit_r       <= 3'd0;
            byte_r      <= 2'd0;
            shift_r     <= 24'd0;
            idx_r       <= '0;
            last_r      <= '0;
            retry_r     <= 3'd0;
            nack_r      <= 1'b0;
            load_wait_r <= 1'b0;
            tbl_idx_o   <= '0;
            busy_o      <= 1'b0;
            cf_done_o   <= 1'b0;
            cf_err_o    <= 1'b0;
            err_idx_o   <= '0;
        end else begin
            if (tick_s) begin
                phase_r <= phase_r + 2'd1;
            end
            case (state_r)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_ok_s) begin
                        cf_done_o   <= 1'b0;
                        cf_err_o    <= 1'b0;
                        busy_o      <= 1'b1;
                        retry_r     <= 3'd0;
                        load_wait_r <= 1'b0;
                        state_r     <= S_LOAD;
                        if (start_cf_i) begin
                            idx_r     <= '0;
                            last_r    <= LAST_IDX;
                            tbl_idx_o <= '0;
                        end else begin
                            idx_r     <= wr_idx_i;
                            last_r    <= wr_idx_i;
                            tbl_idx_o <= wr_idx_i;
                        end
                    end
                end
                S_LOAD: begin
                    // First cycle presents the index, second captures the table word
                    if (!load_wait_r) begin
                        load_wait_r <= 1'b1;
                    end else begin
                        shift_r <= {DEV_ADDR, 1'b0, tbl_data_i};
                        byte_r  <= 2'd0;
                        bit_r   <= 3'd0;
                        phase_r <= 2'd0;
                        nack_r  <= 1'b0;
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (tick_s && (phase_r == 2'd3)) begin
                        bit_r   <= 3'd0;
                        state_r <= S_BIT;
                    end
                end
                S_BIT: begin
                    if (tick_s && (phase_r == 2'd3)) begin
                        shift_r <= {shift_r[22:0], 1'b0};
                        if (bit_r == 3'd7) begin
                            state_r <= S_ACK;
                        end else begin
                            bit_r <= bit_r + 3'd1;
                        end
                    end
                end
                S_ACK: begin
                    if (tick_s && (phase_r == 2'd2)) begin
                        nack_r <= i2c_sda_i;
                    end
                    if (tick_s && (phase_r == 2'd3)) begin
                        if (nack_r || (byte_r == 2'd2)) begin
                            state_r <= S_STOP;
                        end else begin
                            byte_r  <= byte_r + 2'd1;
                            bit_r   <= 3'd0;
                            state_r <= S_BIT;
                        end
                    end
                end
                S_STOP: begin
                    if (tick_s && (phase_r == 2'd3)) begin
                        state_r <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (tick_s && (phase_r == 2'd3)) begin
                        if (!en_i) begin
                            busy_o    <= 1'b0;
                            cf_done_o <= 1'b0;
                            cf_err_o  <= 1'b0;
                            state_r   <= S_IDLE;
                        end else if (nack_r && (retry_r < RETRY_LIM)) begin
                            retry_r     <= retry_r + 3'd1;
                            load_wait_r <= 1'b0;
                            tbl_idx_o   <= idx_r;
                            state_r     <= S_LOAD;
                        end else if (nack_r) begin
                            err_idx_o <= idx_r;
                            cf_err_o  <= 1'b1;
                            busy_o    <= 1'b0;
                            state_r   <= S_ERR;
                        end else if (idx_r == last_r) begin
                            cf_done_o <= 1'b1;
                            busy_o    <= 1'b0;
                            state_r   <= S_DONE;
                        end else begin
                            idx_r       <= idx_r + IDX_W'(1);
                            tbl_idx_o   <= idx_r + IDX_W'(1);
                            retry_r     <= 3'd0;
                            load_wait_r <= 1'b0;
                            state_r     <= S_LOAD;
                        end
                    end
                end
                default: begin
                    busy_o  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    // Bus level decode per state and quarter-bit phase; idle bus everywhere else
    always_comb begin
        scl_s = 1'b1;
        oe_s  = 1'b0;
        case (state_r)
            S_START: begin
                scl_s = (phase_r != 2'd3);
                oe_s  = phase_r[1];
            end
            S_BIT: begin
                scl_s = phase_r[1];
                oe_s  = ~shift_r[23];
            end
            S_ACK: begin
                scl_s = phase_r[1];
                oe_s  = 1'b0;
            end
            S_STOP: begin
                scl_s = (phase_r != 2'd0);
                oe_s  = ~phase_r[1];
            end
            default: begin
                scl_s = 1'b1;
                oe_s  = 1'b0;
            end
        endcase
    end

    // Registered pin drivers; reset releases the bus immediately
    always_ff @(posedge clk_50mhz or negedge rst_ni) begin
        if (!rst_ni) begin
            i2c_sclk_o   <= 1'b1;
            i2c_sda_oe_o <= 1'b0;
        end else begin
            i2c_sclk_o   <= scl_s;
            i2c_sda_oe_o <= oe_s;
        end
    end

endmodule

// File: tb/tb_i2c_codec_cfg_seq.sv
// Bench for i2c_codec_cfg_seq: a bus-level I2C slave decodes frames from the pins
// and ACKs/NACKs according to a per-frame plan; a word-level model of the run
// (retry rules, abort, done) predicts the frame list and final status.
module tb_i2c_codec_cfg_seq;

    localparam int         NUM_REGS  = 3;
    localparam int         CLK_DIV   = 4;
    localparam int         MAX_RETRY = 3;
    localparam int         IDX_W     = 8;
    localparam logic [6:0] DEV_ADDR  = 7'h1A;
    localparam int         WORD_CYC  = 120 * CLK_DIV + 2;
    localparam int         MAXF      = 256;

    logic             clk_50mhz  = 1'b0;
    logic             rst_ni     = 1'b0;
    logic             en_i       = 1'b0;
    logic             start_cf_i = 1'b0;
    logic             wr_one_i   = 1'b0;
    logic [IDX_W-1:0] wr_idx_i   = '0;
    logic [IDX_W-1:0] tbl_idx_o;
    logic [15:0]      tbl_data_i = 16'h0000;
    logic             i2c_sda_i;
    logic             i2c_sda_oe_o;
    logic             i2c_sclk_o;
    logic             busy_o;
    logic             cf_done_o;
    logic             cf_err_o;
    logic [IDX_W-1:0] err_idx_o;

    logic [15:0]      tbl [0:NUM_REGS-1];
    int               plan [0:MAXF-1];        // per frame: byte position to NACK, 3 = ACK all
    logic [31:0]      rx_frames [0:MAXF-1];   // {nbytes, bytes left-aligned}
    int               rx_cnt = 0;
    logic [31:0]      exp_frames [0:MAXF-1];
    int               exp_n;
    logic             exp_done;
    logic             exp_err;
    logic [IDX_W-1:0] exp_err_idx;
    int               pass_cnt  = 0;
    int               total_cnt = 0;

    // slave decoder state
    logic             prev_scl = 1'b1;
    logic             prev_sda = 1'b1;
    logic             in_frame = 1'b0;
    logic             ack_clocked = 1'b0;
    logic             pull = 1'b0;
    int               bitcnt = 0;
    int               nbytes = 0;
    logic [7:0]       sh = 8'h00;
    logic [23:0]      fbytes = 24'h0;

    i2c_codec_cfg_seq #(
        .NUM_REGS (NUM_REGS),
        .DEV_ADDR (DEV_ADDR),
        .CLK_DIV  (CLK_DIV),
        .MAX_RETRY(MAX_RETRY),
        .IDX_W    (IDX_W)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .rst_ni      (rst_ni),
        .en_i        (en_i),
        .start_cf_i  (start_cf_i),
        .wr_one_i    (wr_one_i),
        .wr_idx_i    (wr_idx_i),
        .tbl_idx_o   (tbl_idx_o),
        .tbl_data_i  (tbl_data_i),
        .i2c_sda_i   (i2c_sda_i),
        .i2c_sda_oe_o(i2c_sda_oe_o),
        .i2c_sclk_o  (i2c_sclk_o),
        .busy_o      (busy_o),
        .cf_done_o   (cf_done_o),
        .cf_err_o    (cf_err_o),
        .err_idx_o   (err_idx_o)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    assign i2c_sda_i = ~(i2c_sda_oe_o | pull);

    // Table memory: data becomes valid one cycle after the index changes
    always @(posedge clk_50mhz) begin
        tbl_data_i <= (int'(tbl_idx_o) < NUM_REGS) ? tbl[tbl_idx_o] : 16'hDEAD;
    end

    // Bus-level slave: START/STOP detection, bit capture on SCL rise, ACK drive
    always @(negedge clk_50mhz) begin
        logic scl_v;
        logic sda_v;
        int   p;
        scl_v = i2c_sclk_o;
        sda_v = ~i2c_sda_oe_o;
        if (!rst_ni) begin
            in_frame    = 1'b0;
            ack_clocked = 1'b0;
            pull        = 1'b0;
            bitcnt      = 0;
        end else if (prev_scl && scl_v && prev_sda && !sda_v) begin
            in_frame    = 1'b1;
            bitcnt      = 0;
            nbytes      = 0;
            fbytes      = 24'h0;
            pull        = 1'b0;
            ack_clocked = 1'b0;
        end else if (prev_scl && scl_v && !prev_sda && sda_v) begin
            if (in_frame && (rx_cnt < MAXF)) begin
                rx_frames[rx_cnt] = {8'(nbytes), fbytes};
                rx_cnt = rx_cnt + 1;
            end
            in_frame = 1'b0;
            pull     = 1'b0;
        end else if (!prev_scl && scl_v && in_frame) begin
            if (bitcnt < 8) begin
                sh     = {sh[6:0], sda_v};
                bitcnt = bitcnt + 1;
                if (bitcnt == 8) begin
                    if (nbytes < 3) fbytes[23-8*nbytes -: 8] = sh;
                    p      = (rx_cnt < MAXF) ? plan[rx_cnt] : 3;
                    pull   = (p != nbytes);
                    nbytes = nbytes + 1;
                end
            end else begin
                ack_clocked = 1'b1;
            end
        end else if (prev_scl && !scl_v && ack_clocked) begin
            bitcnt      = 0;
            ack_clocked = 1'b0;
            pull        = 1'b0;
        end
        prev_scl = scl_v;
        prev_sda = sda_v;
    end

    // Word-level reference: each attempt consumes one plan entry; a NACKed attempt
    // carries the bytes up to and including the NACKed one.
    task automatic model_run(input int first, input int last);
        int          f;
        int          p;
        int          n;
        bit          ok;
        logic [23:0] b;
        logic [23:0] m;
        f = rx_cnt;
        exp_n = 0;
        exp_done = 1'b0;
        exp_err = 1'b0;
        for (int w = first; w <= last; w++) begin
            ok = 1'b0;
            for (int a = 0; a <= MAX_RETRY; a++) begin
                p = plan[f];
                f = f + 1;
                n = (p < 3) ? p + 1 : 3;
                b = {DEV_ADDR, 1'b0, tbl[w]};
                m = 24'hFFFFFF;
                m = m << (8 * (3 - n));
                exp_frames[exp_n] = {8'(n), b & m};
                exp_n = exp_n + 1;
                if (p >= 3) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) begin
                exp_err = 1'b1;
                exp_err_idx = IDX_W'(w);
                return;
            end
        end
        exp_done = 1'b1;
    endtask

    function automatic int first_mismatch(input int base);
        for (int i = 0; i < exp_n; i++) begin
            if ((base + i >= MAXF) || (rx_frames[base + i] !== exp_frames[i])) return i;
        end
        return -1;
    endfunction

    task automatic plan_ack(input int from, input int count);
        for (int i = from; i < from + count && i < MAXF; i++) plan[i] = 3;
    endtask

    task automatic pulse(input logic full, input logic one, input logic [IDX_W-1:0] idx);
        @(negedge clk_50mhz);
        start_cf_i = full;
        wr_one_i   = one;
        wr_idx_i   = idx;
        @(negedge clk_50mhz);
        start_cf_i = 1'b0;
        wr_one_i   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int cyc, output bit to);
        cyc = 0;
        to  = 1'b0;
        while (busy_o === 1'b1) begin
            @(negedge clk_50mhz);
            cyc = cyc + 1;
            if (cyc > budget) begin
                to = 1'b1;
                break;
            end
        end
    endtask

    task automatic load_default_table;
        tbl[0] = 16'h1E00;
        tbl[1] = 16'h0C00;
        tbl[2] = 16'h0E42;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        en_i   = 1'b1;
        exp_err_idx = '0;
        repeat (3) @(negedge clk_50mhz);
        total_cnt++; if (i2c_sclk_o !== 1'b1) $display("FAIL reset_scl: got %b want 1", i2c_sclk_o); else pass_cnt++;
        total_cnt++; if (i2c_sda_oe_o !== 1'b0) $display("FAIL reset_oe: got %b want 0", i2c_sda_oe_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", cf_done_o); else pass_cnt++;
        total_cnt++; if (cf_err_o !== 1'b0) $display("FAIL reset_err: got %b want 0", cf_err_o); else pass_cnt++;
        total_cnt++; if (tbl_idx_o !== '0) $display("FAIL reset_tbl_idx: got %0d want 0", tbl_idx_o); else pass_cnt++;
        total_cnt++; if (err_idx_o !== '0) $display("FAIL reset_err_idx: got %0d want 0", err_idx_o); else pass_cnt++;
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_50mhz);
    endtask

    task automatic test_full_run;
        int base; int cyc; bit to; int mm;
        load_default_table();
        base = rx_cnt;
        plan_ack(base, 16);
        model_run(0, NUM_REGS - 1);
        pulse(1'b1, 1'b0, '0);
        wait_idle(5000, cyc, to);
        total_cnt++; if (to) $display("FAIL full_timeout: busy still %b after %0d cycles", busy_o, cyc); else pass_cnt++;
        total_cnt++; if (rx_cnt - base != exp_n) $display("FAIL full_count: got %0d frames want %0d", rx_cnt - base, exp_n); else pass_cnt++;
        mm = first_mismatch(base);
        total_cnt++; if (mm >= 0) $display("FAIL full_frames: frame %0d got %h want %h", mm, rx_frames[base + mm], exp_frames[mm]); else pass_cnt++;
        total_cnt++; if (cyc < NUM_REGS * WORD_CYC - 1 || cyc > NUM_REGS * WORD_CYC + 1) $display("FAIL full_timing: got %0d cycles want %0d +/-1", cyc, NUM_REGS * WORD_CYC); else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b1) $display("FAIL full_done: got %b want 1", cf_done_o); else pass_cnt++;
        total_cnt++; if (cf_err_o !== 1'b0) $display("FAIL full_err: got %b want 0", cf_err_o); else pass_cnt++;
    endtask

    task automatic test_retry_ok;
        int base; int cyc; bit to; int mm;
        load_default_table();
        base = rx_cnt;
        plan_ack(base, 16);
        plan[base + 1] = $urandom_range(0, 2);
        plan[base + 2] = $urandom_range(0, 2);
        model_run(0, NUM_REGS - 1);
        pulse(1'b1, 1'b0, '0);
        wait_idle(8000, cyc, to);
        total_cnt++; if (to) $display("FAIL retry_timeout: busy still %b after %0d cycles", busy_o, cyc); else pass_cnt++;
        total_cnt++; if (rx_cnt - base != exp_n) $display("FAIL retry_count: got %0d frames want %0d", rx_cnt - base, exp_n); else pass_cnt++;
        mm = first_mismatch(base);
        total_cnt++; if (mm >= 0) $display("FAIL retry_frames: frame %0d got %h want %h", mm, rx_frames[base + mm], exp_frames[mm]); else pass_cnt++;
        total_cnt++; if (cf_done_o !== exp_done) $display("FAIL retry_done: got %b want %b", cf_done_o, exp_done); else pass_cnt++;
        total_cnt++; if (cf_err_o !== exp_err) $display("FAIL retry_err: got %b want %b", cf_err_o, exp_err); else pass_cnt++;
        total_cnt++; if (err_idx_o !== exp_err_idx) $display("FAIL retry_err_idx: got %0d want %0d", err_idx_o, exp_err_idx); else pass_cnt++;
    endtask

    task automatic test_wr_one;
        int base; int cyc; bit to; int mm;
        load_default_table();
        base = rx_cnt;
        plan_ack(base, 16);
        model_run(1, 1);
        pulse(1'b0, 1'b1, IDX_W'(1));
        total_cnt++; if (cf_done_o !== 1'b0) $display("FAIL wr_one_done_clear: got %b want 0", cf_done_o); else pass_cnt++;
        wait_idle(2000, cyc, to);
        total_cnt++; if (to) $display("FAIL wr_one_timeout: busy still %b after %0d cycles", busy_o, cyc); else pass_cnt++;
        total_cnt++; if (rx_cnt - base != exp_n) $display("FAIL wr_one_count: got %0d frames want %0d", rx_cnt - base, exp_n); else pass_cnt++;
        mm = first_mismatch(base);
        total_cnt++; if (mm >= 0) $display("FAIL wr_one_frames: frame %0d got %h want %h", mm, rx_frames[base + mm], exp_frames[mm]); else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b1) $display("FAIL wr_one_done: got %b want 1", cf_done_o); else pass_cnt++;
        base = rx_cnt;
        pulse(1'b0, 1'b1, IDX_W'(5));
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL wr_one_bad_idx_busy: got %b want 0", busy_o); else pass_cnt++;
        repeat (50) @(negedge clk_50mhz);
        total_cnt++; if (rx_cnt != base) $display("FAIL wr_one_bad_idx_frames: got %0d frames want 0", rx_cnt - base); else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b1) $display("FAIL wr_one_bad_idx_done: got %b want 1", cf_done_o); else pass_cnt++;
    endtask

    task automatic test_retry_abort;
        int base; int cyc; bit to; int mm;
        load_default_table();
        base = rx_cnt;
        plan_ack(base, 16);
        for (int i = 2; i < 2 + MAX_RETRY + 1; i++) plan[base + i] = $urandom_range(0, 2);
        model_run(0, NUM_REGS - 1);
        pulse(1'b1, 1'b0, '0);
        wait_idle(8000, cyc, to);
        total_cnt++; if (to) $display("FAIL abort_timeout: busy still %b after %0d cycles", busy_o, cyc); else pass_cnt++;
        total_cnt++; if (rx_cnt - base != 2 + MAX_RETRY + 1) $display("FAIL abort_count: got %0d frames want %0d", rx_cnt - base, 2 + MAX_RETRY + 1); else pass_cnt++;
        mm = first_mismatch(base);
        total_cnt++; if (mm >= 0) $display("FAIL abort_frames: frame %0d got %h want %h", mm, rx_frames[base + mm], exp_frames[mm]); else pass_cnt++;
        total_cnt++; if (cf_err_o !== 1'b1) $display("FAIL abort_err: got %b want 1", cf_err_o); else pass_cnt++;
        total_cnt++; if (err_idx_o !== IDX_W'(2)) $display("FAIL abort_err_idx: got %0d want 2", err_idx_o); else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b0) $display("FAIL abort_done: got %b want 0", cf_done_o); else pass_cnt++;
        total_cnt++; if (i2c_sclk_o !== 1'b1 || i2c_sda_oe_o !== 1'b0) $display("FAIL abort_bus_idle: got scl=%b oe=%b want scl=1 oe=0", i2c_sclk_o, i2c_sda_oe_o); else pass_cnt++;
    endtask

    task automatic test_random;
        int base; int cyc; bit to; int mm; bit full; int idx;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < NUM_REGS; w++) tbl[w] = 16'($urandom);
            base = rx_cnt;
            for (int i = base; i < base + 16 && i < MAXF; i++)
                plan[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : 3;
            full = ($urandom_range(0, 1) == 1);
            idx  = $urandom_range(0, NUM_REGS - 1);
            if (full) model_run(0, NUM_REGS - 1);
            else      model_run(idx, idx);
            pulse(full, ~full, IDX_W'(idx));
            wait_idle(8000, cyc, to);
            total_cnt++; if (to) $display("FAIL rand_timeout: iter %0d busy still %b after %0d cycles", it, busy_o, cyc); else pass_cnt++;
            mm = first_mismatch(base);
            total_cnt++;
            if (rx_cnt - base != exp_n) $display("FAIL rand_count: iter %0d got %0d frames want %0d", it, rx_cnt - base, exp_n);
            else if (mm >= 0) $display("FAIL rand_frames: iter %0d frame %0d got %h want %h", it, mm, rx_frames[base + mm], exp_frames[mm]);
            else pass_cnt++;
            total_cnt++;
            if (cf_done_o !== exp_done || cf_err_o !== exp_err || err_idx_o !== exp_err_idx)
                $display("FAIL rand_status: iter %0d got done=%b err=%b idx=%0d want done=%b err=%b idx=%0d",
                         it, cf_done_o, cf_err_o, err_idx_o, exp_done, exp_err, exp_err_idx);
            else pass_cnt++;
        end
    endtask

    task automatic test_en_low;
        int base; int cyc; bit to; int mm;
        load_default_table();
        base = rx_cnt;
        plan_ack(base, 16);
        en_i = 1'b0;
        pulse(1'b1, 1'b0, '0);
        total_cnt++; if (busy_o !== 1'b0) $display("FAIL en_low_start_blocked: got busy=%b want 0", busy_o); else pass_cnt++;
        en_i = 1'b1;
        model_run(0, 0);
        pulse(1'b1, 1'b0, '0);
        repeat (200) @(negedge clk_50mhz);
        en_i = 1'b0;
        wait_idle(2000, cyc, to);
        total_cnt++; if (to) $display("FAIL en_low_timeout: busy still %b after %0d cycles", busy_o, cyc); else pass_cnt++;
        total_cnt++; if (rx_cnt - base != 1) $display("FAIL en_low_count: got %0d frames want 1", rx_cnt - base); else pass_cnt++;
        mm = first_mismatch(base);
        total_cnt++; if (mm >= 0) $display("FAIL en_low_frame: got %h want %h", rx_frames[base], exp_frames[0]); else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b0 || cf_err_o !== 1'b0) $display("FAIL en_low_status: got done=%b err=%b want 0 0", cf_done_o, cf_err_o); else pass_cnt++;
        repeat (600) @(negedge clk_50mhz);
        total_cnt++; if (rx_cnt - base != 1 || busy_o !== 1'b0) $display("FAIL en_low_quiet: got %0d frames busy=%b want 1 frame busy=0", rx_cnt - base, busy_o); else pass_cnt++;
        en_i = 1'b1;
    endtask

    task automatic test_back_to_back;
        int base; int cyc; bit to; int mm;
        load_default_table();
        base = rx_cnt;
        plan_ack(base, 16);
        model_run(0, NUM_REGS - 1);
        pulse(1'b1, 1'b0, '0);
        repeat (600) @(negedge clk_50mhz);
        pulse(1'b1, 1'b1, '0);
        wait_idle(5000, cyc, to);
        cyc = cyc + 602;
        total_cnt++; if (to) $display("FAIL busy_ign_timeout: busy still %b", busy_o); else pass_cnt++;
        total_cnt++; if (rx_cnt - base != exp_n) $display("FAIL busy_ign_count: got %0d frames want %0d", rx_cnt - base, exp_n); else pass_cnt++;
        mm = first_mismatch(base);
        total_cnt++; if (mm >= 0) $display("FAIL busy_ign_frames: frame %0d got %h want %h", mm, rx_frames[base + mm], exp_frames[mm]); else pass_cnt++;
        total_cnt++; if (cyc < NUM_REGS * WORD_CYC - 1 || cyc > NUM_REGS * WORD_CYC + 1) $display("FAIL busy_ign_timing: got %0d cycles want %0d +/-1", cyc, NUM_REGS * WORD_CYC); else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b1) $display("FAIL busy_ign_done: got %b want 1", cf_done_o); else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int base; int cyc; bit to; int mm;
        load_default_table();
        plan_ack(rx_cnt, 32);
        pulse(1'b1, 1'b0, '0);
        repeat (646) @(negedge clk_50mhz);
        rst_ni = 1'b0;
        #1;
        exp_err_idx = '0;
        total_cnt++; if (i2c_sclk_o !== 1'b1 || i2c_sda_oe_o !== 1'b0) $display("FAIL mid_reset_bus: got scl=%b oe=%b want scl=1 oe=0", i2c_sclk_o, i2c_sda_oe_o); else pass_cnt++;
        total_cnt++; if (busy_o !== 1'b0 || cf_done_o !== 1'b0 || cf_err_o !== 1'b0) $display("FAIL mid_reset_status: got busy=%b done=%b err=%b want 0 0 0", busy_o, cf_done_o, cf_err_o); else pass_cnt++;
        total_cnt++; if (tbl_idx_o !== '0 || err_idx_o !== '0) $display("FAIL mid_reset_idx: got tbl_idx=%0d err_idx=%0d want 0 0", tbl_idx_o, err_idx_o); else pass_cnt++;
        repeat (3) @(negedge clk_50mhz);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_50mhz);
        base = rx_cnt;
        plan_ack(base, 16);
        model_run(0, NUM_REGS - 1);
        pulse(1'b1, 1'b0, '0);
        wait_idle(5000, cyc, to);
        total_cnt++; if (to) $display("FAIL post_reset_timeout: busy still %b", busy_o); else pass_cnt++;
        mm = first_mismatch(base);
        total_cnt++;
        if (rx_cnt - base != exp_n) $display("FAIL post_reset_count: got %0d frames want %0d", rx_cnt - base, exp_n);
        else if (mm >= 0) $display("FAIL post_reset_frames: frame %0d got %h want %h", mm, rx_frames[base + mm], exp_frames[mm]);
        else pass_cnt++;
        total_cnt++; if (cf_done_o !== 1'b1 || cf_err_o !== 1'b0) $display("FAIL post_reset_status: got done=%b err=%b want 1 0", cf_done_o, cf_err_o); else pass_cnt++;
    endtask

    initial begin
        for (int i = 0; i < MAXF; i++) plan[i] = 3;
        load_default_table();
        test_reset();
        test_full_run();
        test_retry_ok();
        test_wr_one();
        test_retry_abort();
        test_random();
        test_en_low();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
